// File: rtl/rr_lock_arbiter_if.sv
// Request/grant bundle between the requesters and the lock arbiter.
// master = requester side (drives en/req), slave = arbiter side (drives grants).
interface rr_lock_arbiter_if #(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
);
  logic            en;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic [ID_W-1:0] gnt_id;
  logic            busy;
  logic            timeout;

  modport master (output en, req, input gnt, gnt_id, busy, timeout);
  modport slave  (input en, req, output gnt, gnt_id, busy, timeout);
endinterface

// File: rtl/rr_lock_arbiter.sv
// Round-robin lock arbiter: registers a one-hot grant, holds it while the owner's
// request stays high (bounded by MAX_HOLD), then rotates priority past the owner.
// Always inserts one idle cycle between grants so the downstream chain can settle.

// Per-lane helper: flags a request that sits at or above the rotation pointer,
// i.e. one that is "ahead" in the circular search before wrap-around.
module rr_lock_lane #(
  parameter int ID_W = 2,
  parameter int LANE = 0
) (
  input  logic            req_bit,
  input  logic [ID_W-1:0] ptr,
  output logic            hi
);
  assign hi = req_bit && (ID_W'(LANE) >= ptr);
endmodule

module rr_lock_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = (N > 1) ? $clog2(N) : 1,
  parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  rr_lock_arbiter_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state;
  logic [N-1:0]     gnt_q;
  logic [ID_W-1:0]  gnt_id_q;
  logic             busy_q;
  logic             timeout_q;
  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic [N-1:0]     hi_req;
  logic [ID_W-1:0]  win;
  logic             owner_req;
  logic             hold_hit;

  // Lanes split requests into "at/after ptr" and "before ptr" halves of the ring.
  for (genvar i = 0; i < N; i++) begin : g_lane
    rr_lock_lane #(.ID_W(ID_W), .LANE(i)) u_lane (
      .req_bit (bus.req[i]),
      .ptr     (ptr),
      .hi      (hi_req[i])
    );
  end

  // Circular priority pick: lowest set bit at/after ptr, else lowest set bit overall.
  always_comb begin
    win = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req[i]) win = ID_W'(i);
    end
    if (|hi_req) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (hi_req[i]) win = ID_W'(i);
      end
    end
  end

  assign owner_req = bus.req[gnt_id_q];
  assign hold_hit  = (hold_cnt == CNT_W'(MAX_HOLD));

  // Two-state grant FSM; every output is a register so the chain sees clean levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.en && |bus.req) begin
            gnt_q    <= N'(1) << win;
            gnt_id_q <= win;
            busy_q   <= 1'b1;
            hold_cnt <= CNT_W'(1);
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!owner_req || hold_hit) begin
            // Request drop wins over the hold limit when both land on the same edge.
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            hold_cnt  <= '0;
            timeout_q <= owner_req;
            ptr       <= (gnt_id_q == ID_W'(N - 1)) ? '0 : gnt_id_q + 1'b1;
            state     <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, all compared
// against a cycle-level reference model of the arbitration rules.
module tb_rr_lock_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int ID_W     = 2;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   cyc;

  rr_lock_arbiter_if #(.N(N), .ID_W(ID_W)) bus ();

  rr_lock_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: owner index (-1 = none), cycles held, rotation start.
  int m_owner;
  int m_cnt;
  int m_ptr;
  int m_last;
  bit m_timeout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_cnt     = 0;
    m_ptr     = 0;
    m_last    = 0;
    m_timeout = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic e);
    m_timeout = 0;
    if (m_owner < 0) begin
      if (e && r != 0) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_ptr + k) % N;
          if (r[idx]) begin
            m_owner = idx;
            m_cnt   = 1;
            break;
          end
        end
      end
    end else begin
      if (!r[m_owner] || m_cnt == MAX_HOLD) begin
        m_timeout = r[m_owner];
        m_ptr     = (m_owner + 1) % N;
        m_last    = m_owner;
        m_owner   = -1;
        m_cnt     = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg;
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    chk("gnt", 32'(bus.gnt), 32'(eg));
    chk("busy", 32'(bus.busy), 32'(m_owner >= 0));
    chk("timeout", 32'(bus.timeout), 32'(m_timeout));
    if (m_owner >= 0) chk("gnt_id", 32'(bus.gnt_id), 32'(m_owner));
  endtask

  // One clock: drive at negedge, model the edge, check shortly after it.
  task automatic step(input logic [N-1:0] r, input logic e);
    @(negedge clk);
    bus.req = r;
    bus.en  = e;
    @(posedge clk);
    model_edge(r, e);
    cyc++;
    #1;
    check_outputs();
  endtask

  initial begin
    logic [N-1:0] rr;
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    reset_n = 1'b0;
    bus.req = '0;
    bus.en  = 1'b0;
    model_reset();
    #12;
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_timeout", 32'(bus.timeout), 32'h0);
    chk("rst_gnt_id", 32'(bus.gnt_id), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: idle with no requests
    repeat (5) step('0, 1'b1);

    // 2: 0101 from ptr 0 -> requester 0, then 2 after one idle cycle
    step(4'b0101, 1'b1);
    chk("t2_gnt0", 32'(bus.gnt), 32'h1);
    step(4'b0100, 1'b1);
    chk("t2_gap", 32'(bus.gnt), 32'h0);
    step(4'b0100, 1'b1);
    chk("t2_gnt2", 32'(bus.gnt), 32'h4);
    chk("t2_id2", 32'(bus.gnt_id), 32'h2);
    step('0, 1'b1);
    step('0, 1'b1);

    // 3: single requester hits the hold limit and is re-granted
    repeat (20) step(4'b0010, 1'b1);
    step('0, 1'b1);
    step('0, 1'b1);

    // 4: all requesting -> full rotation with timeouts
    repeat (46) step(4'b1111, 1'b1);
    step('0, 1'b1);
    step('0, 1'b1);

    // 5: reset mid-grant drops the grant asynchronously; ptr restarts at 0
    step(4'b0010, 1'b1);
    step(4'b0010, 1'b0);
    step('0, 1'b1);
    step(4'b0100, 1'b1);
    step(4'b0100, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async_gnt", 32'(bus.gnt), 32'h0);
    chk("t5_async_busy", 32'(bus.busy), 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(4'b0100, 1'b1);
    chk("t5_regrant", 32'(bus.gnt), 32'h4);
    step('0, 1'b1);

    // 6: en gates new grants only
    repeat (3) step(4'b0011, 1'b0);
    step(4'b0011, 1'b1);
    chk("t6_gnt0", 32'(bus.gnt), 32'h1);
    repeat (4) step(4'b0011, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b1);

    // randomized traffic with sticky requests and occasional en drops
    rr = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(5) == 0) rr[b] = ~rr[b];
      end
      step(rr, ($urandom_range(9) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
